// File: rtl/neopix_tx.sv
// WS2812 serializer: byte FIFO feeding an MSB-first pulse-width bit encoder,
// followed by a low latch interval once the FIFO runs dry after a frame.
module neopix_tx #(
  parameter int TBIT       = 63,
  parameter int T0H        = 20,
  parameter int T1H        = 40,
  parameter int TRESET     = 3000,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk_i,
  input  logic                          reset_n_i,
  input  logic [7:0]                    data_i,
  input  logic                          valid_i,
  output logic                          dout_o,
  output logic                          busy_o,
  output logic                          frame_done_o,
  output logic                          overflow_o,
  output logic [$clog2(FIFO_DEPTH):0]   level_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(TBIT);
  localparam int LW = (TRESET > 1) ? $clog2(TRESET) : 1;

  localparam logic [CW-1:0] CYC_LAST = CW'(TBIT - 1);
  localparam logic [CW-1:0] T0H_C    = CW'(T0H);
  localparam logic [CW-1:0] T1H_C    = CW'(T1H);
  localparam logic [LW-1:0] LAT_LAST = LW'(TRESET - 1);
  localparam logic [AW:0]   LVL_FULL = (AW + 1)'(FIFO_DEPTH);

  generate
    if (!(T0H >= 1 && T0H < T1H && T1H < TBIT && TBIT >= 4 && FIFO_DEPTH >= 2 &&
          (FIFO_DEPTH & (FIFO_DEPTH - 1)) == 0)) begin : g_bad_params
      $error("neopix_tx: illegal parameter set");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    LATCH = 2'd2
  } state_t;

  state_t          state_reg, state_next;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]     level_reg;
  logic            ovf_reg;
  logic [7:0]      shift_reg, shift_next;
  logic [2:0]      bitcnt_reg, bitcnt_next;
  logic [CW-1:0]   cyc_reg, cyc_next;
  logic [LW-1:0]   lat_reg, lat_next;
  logic            dout_reg, dout_next;
  logic            done_reg, done_next;
  logic            pop, push, empty, full;
  logic [7:0]      head;
  logic [CW-1:0]   high_len;

  assign empty = (level_reg == '0);
  assign full  = (level_reg == LVL_FULL);
  // A pop in the same cycle frees a slot, so a full FIFO still accepts.
  assign push  = valid_i && (!full || pop);
  assign head  = mem[rd_ptr_reg];

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr_reg] <= data_i;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
      ovf_reg    <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      case ({push, pop})
        2'b10:   level_reg <= level_reg + (AW + 1)'(1);
        2'b01:   level_reg <= level_reg - (AW + 1)'(1);
        default: level_reg <= level_reg;
      endcase
      if (valid_i && full && !pop) begin
        ovf_reg <= 1'b1;
      end
    end
  end

  always_comb begin
    state_next  = state_reg;
    shift_next  = shift_reg;
    bitcnt_next = bitcnt_reg;
    cyc_next    = cyc_reg;
    lat_next    = lat_reg;
    done_next   = 1'b0;
    pop         = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!empty) begin
          pop         = 1'b1;
          shift_next  = head;
          bitcnt_next = '0;
          cyc_next    = '0;
          state_next  = SEND;
        end
      end
      SEND: begin
        if (cyc_reg == CYC_LAST) begin
          cyc_next = '0;
          if (bitcnt_reg != 3'd7) begin
            shift_next  = {shift_reg[6:0], 1'b0};
            bitcnt_next = bitcnt_reg + 3'd1;
          end else if (!empty) begin
            // Next byte starts on the very next edge: no inter-byte gap.
            pop         = 1'b1;
            shift_next  = head;
            bitcnt_next = '0;
          end else begin
            lat_next   = '0;
            state_next = LATCH;
          end
        end else begin
          cyc_next = cyc_reg + CW'(1);
        end
      end
      LATCH: begin
        if (lat_reg == LAT_LAST) begin
          done_next  = 1'b1;
          state_next = IDLE;
        end else begin
          lat_next = lat_reg + LW'(1);
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    // Line level is derived from the post-edge bit position so dout is registered.
    high_len  = shift_next[7] ? T1H_C : T0H_C;
    dout_next = (state_next == SEND) && (cyc_next < high_len);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_reg  <= IDLE;
      shift_reg  <= '0;
      bitcnt_reg <= '0;
      cyc_reg    <= '0;
      lat_reg    <= '0;
      dout_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      shift_reg  <= shift_next;
      bitcnt_reg <= bitcnt_next;
      cyc_reg    <= cyc_next;
      lat_reg    <= lat_next;
      dout_reg   <= dout_next;
      done_reg   <= done_next;
    end
  end

  assign dout_o       = dout_reg;
  assign frame_done_o = done_reg;
  assign overflow_o   = ovf_reg;
  assign level_o      = level_reg;
  assign busy_o       = (state_reg != IDLE) || !empty;

endmodule

// File: tb/tb_neopix_tx.sv
// Self-checking bench: two serializers (default and minimum timing) with a line
// monitor that logs pulses; logs are judged against the pushed byte stream.
module tb_neopix_tx;

  localparam int TBIT0 = 63, T0H0 = 20, T1H0 = 40, TRST0 = 3000;
  localparam int TBIT1 = 4,  T0H1 = 1,  T1H1 = 2,  TRST1 = 5;
  localparam int NMAX  = 512;

  logic       clk = 1'b0;
  logic [1:0] rst_n, valid_v, clr;
  logic [7:0] data0, data1;
  logic       dout0, dout1, busy0, busy1, fd0, fd1, ovf0, ovf1;
  logic [4:0] level0, level1;
  logic [1:0] dout_v, busy_v, fd_v, ovf_v;

  assign dout_v = {dout1, dout0};
  assign busy_v = {busy1, busy0};
  assign fd_v   = {fd1, fd0};
  assign ovf_v  = {ovf1, ovf0};

  neopix_tx #(.TBIT(TBIT0), .T0H(T0H0), .T1H(T1H0), .TRESET(TRST0), .FIFO_DEPTH(16)) u_dut0 (
    .clk_i(clk), .reset_n_i(rst_n[0]), .data_i(data0), .valid_i(valid_v[0]),
    .dout_o(dout0), .busy_o(busy0), .frame_done_o(fd0), .overflow_o(ovf0), .level_o(level0)
  );

  neopix_tx #(.TBIT(TBIT1), .T0H(T0H1), .T1H(T1H1), .TRESET(TRST1), .FIFO_DEPTH(16)) u_dut1 (
    .clk_i(clk), .reset_n_i(rst_n[1]), .data_i(data1), .valid_i(valid_v[1]),
    .dout_o(dout1), .busy_o(busy1), .frame_done_o(fd1), .overflow_o(ovf1), .level_o(level1)
  );

  always #5 clk = ~clk;

  int cnt = 0;
  always @(posedge clk) cnt <= cnt + 1;

  // Pulse log per instance: rise time and high width of each completed bit, and frame_done times.
  int   rise_t [2][NMAX];
  int   hw     [2][NMAX];
  int   fd_t   [2][16];
  int   fd_bits[2][16];
  int   n_bits [2];
  int   n_rise [2];
  int   n_fd   [2];
  int   rise_cur[2];
  logic prev   [2];

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n[i]) begin
        prev[i] <= 1'b0;
      end else if (clr[i]) begin
        n_bits[i] <= 0;
        n_rise[i] <= 0;
        n_fd[i]   <= 0;
        prev[i]   <= dout_v[i];
      end else begin
        prev[i] <= dout_v[i];
        if (dout_v[i] && !prev[i]) begin
          rise_cur[i] <= cnt;
          n_rise[i]   <= n_rise[i] + 1;
        end
        if (!dout_v[i] && prev[i] && n_bits[i] < NMAX) begin
          rise_t[i][n_bits[i]] <= rise_cur[i];
          hw[i][n_bits[i]]     <= cnt - rise_cur[i];
          n_bits[i]            <= n_bits[i] + 1;
        end
        if (fd_v[i] && n_fd[i] < 16) begin
          fd_t[i][n_fd[i]]    <= cnt;
          fd_bits[i][n_fd[i]] <= n_bits[i];
          n_fd[i]             <= n_fd[i] + 1;
        end
      end
    end
  end

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];
  int strobe_t;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int tbit_of(input int i);  return (i == 0) ? TBIT0 : TBIT1; endfunction
  function automatic int t0h_of(input int i);   return (i == 0) ? T0H0 : T0H1;   endfunction
  function automatic int t1h_of(input int i);   return (i == 0) ? T1H0 : T1H1;   endfunction
  function automatic int trst_of(input int i);  return (i == 0) ? TRST0 : TRST1; endfunction
  function automatic int level_of(input int i); return (i == 0) ? int'(level0) : int'(level1); endfunction

  task automatic clear_log(input int i);
    clr[i] = 1'b1;
    repeat (2) @(negedge clk);
    clr[i] = 1'b0;
  endtask

  task automatic push(input int i, input logic [7:0] b);
    @(negedge clk);
    if (i == 0) data0 = b; else data1 = b;
    valid_v[i] = 1'b1;
    strobe_t = cnt;
    exp_q.push_back(b);
    @(negedge clk);
    valid_v[i] = 1'b0;
  endtask

  task automatic wait_idle(input int i, input string tag);
    int k;
    k = 0;
    @(negedge clk);
    while (busy_v[i] && k < 40000) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_idle_wait"}, (k < 40000), 1);
    repeat (3) @(negedge clk);
  endtask

  // Judge the logged line activity against the expected byte stream using the WS2812 rules.
  task automatic verify_stream(input int i, input int frames, input string tag);
    int nb, sep, b;
    logic [7:0] bv;
    check({tag, "_nbits"}, n_bits[i], 8 * exp_q.size());
    nb = (n_bits[i] < 8 * exp_q.size()) ? n_bits[i] : 8 * exp_q.size();
    for (int k = 0; k < nb; k++) begin
      bv = exp_q[k / 8];
      check($sformatf("%s_width%0d", tag, k), hw[i][k], bv[7 - (k % 8)] ? t1h_of(i) : t0h_of(i));
    end
    for (int k = 0; k + 1 < nb; k++) begin
      sep = -1;
      for (int f = 0; f < n_fd[i]; f++) if (fd_bits[i][f] == k + 1) sep = f;
      if (sep < 0)
        check($sformatf("%s_period%0d", tag, k), rise_t[i][k + 1] - rise_t[i][k], tbit_of(i));
      else
        check($sformatf("%s_restart%0d", tag, k), (rise_t[i][k + 1] > fd_t[i][sep]), 1);
    end
    for (int f = 0; f < n_fd[i]; f++) begin
      b = fd_bits[i][f];
      check($sformatf("%s_fd_align%0d", tag, f), ((b > 0) && (b % 8 == 0)), 1);
      if (b > 0 && b <= nb)
        check($sformatf("%s_fd_time%0d", tag, f), fd_t[i][f] - rise_t[i][b - 1],
              tbit_of(i) + trst_of(i));
    end
    check({tag, "_ends_in_latch"}, (n_fd[i] > 0) ? fd_bits[i][n_fd[i] - 1] : -1, n_bits[i]);
    if (frames >= 0) check({tag, "_frames"}, n_fd[i], frames);
  endtask

  initial begin
    int s0, lat_at, nb, g, lvl_max, exp_lvl;
    logic [7:0] ob [20];

    rst_n = 2'b00; valid_v = 2'b00; clr = 2'b00; data0 = '0; data1 = '0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("rst_dout", dout_v[i], 0);
      check("rst_busy", busy_v[i], 0);
      check("rst_fdone", fd_v[i], 0);
      check("rst_ovf", ovf_v[i], 0);
      check("rst_level", level_of(i), 0);
    end
    rst_n = 2'b11;
    clear_log(0);
    clear_log(1);
    check("idle_dout", dout_v[0], 0);
    check("idle_busy", busy_v[0], 0);

    // Single byte 0xA5 at default timing.
    exp_q.delete();
    push(0, 8'hA5);
    s0 = strobe_t;
    wait_idle(0, "single");
    check("single_latency", rise_t[0][0] - s0, 2);
    verify_stream(0, 1, "single");
    $display("txn single byte A5: bits=%0d frames=%0d", n_bits[0], n_fd[0]);

    // Back-to-back pixel, 10 cycles apart.
    clear_log(0);
    exp_q.delete();
    push(0, 8'hFF); repeat (8) @(negedge clk);
    push(0, 8'h00); repeat (8) @(negedge clk);
    push(0, 8'h81);
    wait_idle(0, "pixel");
    verify_stream(0, 1, "pixel");
    $display("txn pixel FF 00 81: bits=%0d frames=%0d", n_bits[0], n_fd[0]);

    // Overflow: 20 consecutive strobes from idle; one pops at once, 16 queue, 3 drop.
    clear_log(0);
    exp_q.delete();
    lvl_max = 0;
    for (int j = 0; j < 20; j++) begin
      ob[j] = 8'($urandom);
      data0 = ob[j];
      valid_v[0] = 1'b1;
      @(negedge clk);
      exp_lvl = j + 1 - ((j >= 1) ? 1 : 0);
      if (exp_lvl > 16) exp_lvl = 16;
      check($sformatf("ovf_level%0d", j), level_of(0), exp_lvl);
      check($sformatf("ovf_flag%0d", j), ovf_v[0], (j >= 17) ? 1 : 0);
      if (level_of(0) > lvl_max) lvl_max = level_of(0);
    end
    valid_v[0] = 1'b0;
    for (int j = 0; j < 17; j++) exp_q.push_back(ob[j]);
    check("ovf_level_peak", lvl_max, 16);
    wait_idle(0, "ovf");
    verify_stream(0, 1, "ovf");
    check("ovf_sticky", ovf_v[0], 1);
    $display("txn overflow burst 20: bits=%0d frames=%0d peak=%0d", n_bits[0], n_fd[0], lvl_max);

    // Push during latch: second byte must wait for the whole latch and frame_done.
    clear_log(0);
    exp_q.delete();
    push(0, 8'h01);
    lat_at = strobe_t + 2 + 8 * TBIT0 + 100;
    while (cnt < lat_at) @(negedge clk);
    check("latch_bits_before", n_bits[0], 8);
    check("latch_no_fd_yet", n_fd[0], 0);
    data0 = 8'h80;
    valid_v[0] = 1'b1;
    exp_q.push_back(8'h80);
    @(negedge clk);
    valid_v[0] = 1'b0;
    check("latch_level", level_of(0), 1);
    check("latch_dout_low", dout_v[0], 0);
    wait_idle(0, "latch");
    verify_stream(0, 2, "latch");
    check("latch_new_frame_rise", rise_t[0][8] - fd_t[0][0], 1);
    $display("txn push during latch: bits=%0d frames=%0d", n_bits[0], n_fd[0]);

    // Asynchronous reset in the middle of bit 3 of 0xF0 with two bytes queued.
    clear_log(0);
    exp_q.delete();
    push(0, 8'hF0);
    s0 = strobe_t;
    push(0, 8'h11);
    push(0, 8'h22);
    while (cnt < s0 + 2 + 3 * TBIT0 + 10) @(negedge clk);
    check("rstmid_level_before", level_of(0), 2);
    check("rstmid_ovf_before", ovf_v[0], 1);
    check("rstmid_dout_before", dout_v[0], 1);
    #2 rst_n[0] = 1'b0;
    #1;
    check("rstmid_dout", dout_v[0], 0);
    check("rstmid_level", level_of(0), 0);
    check("rstmid_ovf", ovf_v[0], 0);
    check("rstmid_busy", busy_v[0], 0);
    check("rstmid_fdone", fd_v[0], 0);
    @(negedge clk);
    rst_n[0] = 1'b1;
    clear_log(0);
    repeat (4000) @(negedge clk);
    check("rstmid_no_rise", n_rise[0], 0);
    check("rstmid_no_fdone", n_fd[0], 0);
    check("rstmid_idle_busy", busy_v[0], 0);
    $display("txn reset mid-bit: rises_after=%0d frames_after=%0d", n_rise[0], n_fd[0]);

    // Minimum timing instance: single 0x5A.
    clear_log(1);
    exp_q.delete();
    push(1, 8'h5A);
    s0 = strobe_t;
    wait_idle(1, "min");
    check("min_latency", rise_t[1][0] - s0, 2);
    verify_stream(1, 1, "min");
    $display("txn min params 5A: bits=%0d frames=%0d", n_bits[1], n_fd[1]);

    // Random streams with random spacing; underflow may split them into several frames.
    for (int it = 0; it < 6; it++) begin
      clear_log(1);
      exp_q.delete();
      nb = int'($urandom_range(1, 10));
      for (int k = 0; k < nb; k++) begin
        push(1, 8'($urandom));
        g = int'($urandom_range(0, 60));
        repeat (g) @(negedge clk);
      end
      wait_idle(1, "rnd_min");
      verify_stream(1, -1, $sformatf("rnd_min%0d", it));
      $display("txn random min-param stream %0d: bytes=%0d frames=%0d", it, nb, n_fd[1]);
    end
    for (int it = 0; it < 2; it++) begin
      clear_log(0);
      exp_q.delete();
      nb = int'($urandom_range(1, 5));
      for (int k = 0; k < nb; k++) begin
        push(0, 8'($urandom));
        g = int'($urandom_range(0, 600));
        repeat (g) @(negedge clk);
      end
      wait_idle(0, "rnd_def");
      verify_stream(0, -1, $sformatf("rnd_def%0d", it));
      $display("txn random default stream %0d: bytes=%0d frames=%0d", it, nb, n_fd[0]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
